// File: rtl/riscv_pkg.sv
// Shared opcode, funct and ALU operation encodings for the single-cycle RV32I core.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  function automatic logic [31:0] sign_extend_imm(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/riscv_processor_core_fetch.sv
// PC register plus instruction memory; the fetch index wraps on pc[9:2].
module instruction_fetch #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic [31:0] instruction
);

  // Loaded directly by the surrounding environment; deliberately never reset.
  logic [31:0] instruction_memory [0:IMEM_DEPTH-1];

  // PC advances one word per clock, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc + 32'd4;
    end
  end

  assign instruction = instruction_memory[pc[9:2]];

endmodule

// File: rtl/riscv_processor_core_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
module register_file (
  input  logic        clk,
  input  logic        write_enable,
  input  logic [4:0]  read_addr1,
  input  logic [4:0]  read_addr2,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  logic [31:0] reg_array [0:31];

  // Write port; contents have no reset so preloaded values survive it.
  always_ff @(posedge clk) begin
    if (write_enable && (write_addr != 5'd0)) begin
      reg_array[write_addr] <= write_data;
    end
  end

  assign read_data1 = (read_addr1 == 5'd0) ? 32'd0 : reg_array[read_addr1];
  assign read_data2 = (read_addr2 == 5'd0) ? 32'd0 : reg_array[read_addr2];

endmodule

// File: rtl/riscv_processor_core.sv
// Single-cycle RV32I core supporting R-type and I-type ALU instructions only.
module riscv_processor_core
  import riscv_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out
);

  logic [31:0] pc;
  logic [31:0] fetched_instruction;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  alu_op_e     alu_control;
  logic        regwrite_control;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] operand_b;
  logic [4:0]  shamt;

  instruction_fetch #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .RESET_PC   (RESET_PC)
  ) instruction_fetch_unit (
    .clk         (clk),
    .rst_n       (reset),
    .pc          (pc),
    .instruction (fetched_instruction)
  );

  assign opcode = fetched_instruction[6:0];
  assign rd     = fetched_instruction[11:7];
  assign funct3 = fetched_instruction[14:12];
  assign rs1    = fetched_instruction[19:15];
  assign rs2    = fetched_instruction[24:20];
  assign funct7 = fetched_instruction[31:25];
  assign imm    = sign_extend_imm(fetched_instruction);

  // Writes are held off while reset is asserted so the register file keeps its contents.
  register_file register_file_unit (
    .clk          (clk),
    .write_enable (regwrite_control & reset),
    .read_addr1   (rs1),
    .read_addr2   (rs2),
    .write_addr   (rd),
    .write_data   (alu_result),
    .read_data1   (read_data1),
    .read_data2   (read_data2)
  );

  // Control: map opcode/funct to ALU operation; anything unlisted becomes a NOP.
  always_comb begin
    alu_control      = ALU_ADD;
    regwrite_control = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ITYPE: begin
        regwrite_control = 1'b1;
        case (funct3)
          F3_ADD: begin
            if (opcode == OP_ITYPE || funct7 == F7_BASE) begin
              alu_control = ALU_ADD;
            end else if (funct7 == F7_ALT) begin
              alu_control = ALU_SUB;
            end else begin
              regwrite_control = 1'b0;
            end
          end
          F3_SLL:  alu_control = ALU_SLL;
          F3_SLT:  alu_control = ALU_SLT;
          F3_SLTU: alu_control = ALU_SLTU;
          F3_XOR:  alu_control = ALU_XOR;
          F3_SR: begin
            if (funct7 == F7_BASE || (opcode == OP_ITYPE && !funct7[5])) begin
              alu_control = ALU_SRL;
            end else if (funct7 == F7_ALT || (opcode == OP_ITYPE && funct7[5])) begin
              alu_control = ALU_SRA;
            end else begin
              regwrite_control = 1'b0;
            end
          end
          F3_OR:   alu_control = ALU_OR;
          F3_AND:  alu_control = ALU_AND;
          default: regwrite_control = 1'b0;
        endcase
      end
      default: begin
        alu_control      = ALU_ADD;
        regwrite_control = 1'b0;
      end
    endcase
  end

  assign operand_b = (opcode == OP_RTYPE) ? read_data2 : imm;
  assign shamt     = operand_b[4:0];

  // ALU datapath.
  always_comb begin
    case (alu_control)
      ALU_AND:  alu_result = read_data1 & operand_b;
      ALU_OR:   alu_result = read_data1 | operand_b;
      ALU_ADD:  alu_result = read_data1 + operand_b;
      ALU_XOR:  alu_result = read_data1 ^ operand_b;
      ALU_SLL:  alu_result = read_data1 << shamt;
      ALU_SRL:  alu_result = read_data1 >> shamt;
      ALU_SUB:  alu_result = read_data1 - operand_b;
      ALU_SRA:  alu_result = $unsigned($signed(read_data1) >>> shamt);
      ALU_SLT:  alu_result = {31'd0, ($signed(read_data1) < $signed(operand_b))};
      ALU_SLTU: alu_result = {31'd0, (read_data1 < operand_b)};
      default:  alu_result = 32'd0;
    endcase
  end

  assign zero_flag       = (alu_result == 32'd0);
  assign pc_out          = pc;
  assign instruction_out = fetched_instruction;

endmodule

// File: tb/tb_riscv_processor_core.sv
// Directed program table, reset corner cases and a randomized run against an instruction-level model.
module tb_riscv_processor_core;

  logic        clk;
  logic        reset;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_regs [0:31];
  logic [31:0] model_mem  [0:255];
  logic [31:0] model_pc;

  riscv_processor_core dut (
    .clk             (clk),
    .reset           (reset),
    .pc_out          (pc_out),
    .instruction_out (instruction_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  chk_reg;
    logic [31:0] exp;
    logic        chk_zero;
  } vec_t;

  vec_t tbl [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {im, rs1, f3, rd, 7'h13};
  endfunction

  // Instruction-level reference: executes one instruction on the model state.
  task automatic model_step(input logic [31:0] ins);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] v;
    logic        ok;
    logic [6:0]  op;
    op = ins[6:0];
    a  = model_regs[ins[19:15]];
    b  = (op == 7'h33) ? model_regs[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
    v  = 32'd0;
    ok = (op == 7'h33) || (op == 7'h13);
    if (ok) begin
      case (ins[14:12])
        3'd0: v = (op == 7'h33 && ins[31:25] == 7'h20) ? a - b : a + b;
        3'd1: v = a << b[4:0];
        3'd2: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: v = (a < b) ? 32'd1 : 32'd0;
        3'd4: v = a ^ b;
        3'd5: v = ins[30] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: v = a | b;
        default: v = a & b;
      endcase
      if (ins[11:7] != 5'd0) model_regs[ins[11:7]] = v;
    end
    model_pc = model_pc + 32'd4;
  endtask

  function automatic logic [31:0] rand_instr();
    int          kind;
    logic [2:0]  f3;
    logic [11:0] im;
    logic [6:0]  f7;
    logic [31:0] w;
    kind = $urandom_range(0, 9);
    f3   = 3'($urandom_range(0, 7));
    im   = 12'($urandom);
    w    = $urandom;
    if (kind < 4) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00;
      return enc_r(f7, w[24:20], w[19:15], f3, w[11:7]);
    end else if (kind < 9) begin
      if (f3 == 3'd1) im[11:5] = 7'h00;
      else if (f3 == 3'd5) im[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return enc_i(im, w[19:15], f3, w[11:7]);
    end else begin
      w[6:0] = ($urandom_range(0, 1) == 1) ? 7'h7F : 7'h03;
      return w;
    end
  endfunction

  initial begin
    logic [31:0] ins;
    reset = 1'b0;
    tbl[0]  = '{enc_r(7'h00, 5'd5, 5'd6, 3'd0, 5'd7),  5'd7,  32'd3,        1'b0};
    tbl[1]  = '{enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd12), 5'd12, 32'd3,        1'b0};
    tbl[2]  = '{32'h40528433,                          5'd8,  32'd0,        1'b1};
    tbl[3]  = '{enc_i(12'hFFF, 5'd0, 3'd0, 5'd9),      5'd9,  32'hFFFFFFFF, 1'b0};
    tbl[4]  = '{enc_r(7'h00, 5'd5, 5'd9, 3'd2, 5'd10), 5'd10, 32'd1,        1'b0};
    tbl[5]  = '{enc_r(7'h00, 5'd5, 5'd9, 3'd3, 5'd11), 5'd11, 32'd0,        1'b0};
    tbl[6]  = '{enc_i(12'h404, 5'd9, 3'd5, 5'd13),     5'd13, 32'hFFFFFFFF, 1'b0};
    tbl[7]  = '{enc_i(12'h004, 5'd9, 3'd5, 5'd14),     5'd14, 32'h0FFFFFFF, 1'b0};
    tbl[8]  = '{enc_i(12'h005, 5'd0, 3'd0, 5'd0),      5'd0,  32'd0,        1'b0};
    tbl[9]  = '{32'h0000007F,                          5'd7,  32'd3,        1'b0};
    tbl[10] = '{enc_r(7'h00, 5'd7, 5'd6, 3'd1, 5'd15), 5'd15, 32'd16,       1'b0};
    tbl[11] = '{enc_r(7'h00, 5'd5, 5'd9, 3'd4, 5'd16), 5'd16, 32'hFFFFFFFE, 1'b0};
    tbl[12] = '{enc_r(7'h00, 5'd5, 5'd6, 3'd6, 5'd17), 5'd17, 32'd3,        1'b0};
    tbl[13] = '{enc_r(7'h00, 5'd6, 5'd7, 3'd7, 5'd18), 5'd18, 32'd2,        1'b0};
    tbl[14] = '{enc_i(12'h000, 5'd9, 3'd2, 5'd19),     5'd19, 32'd1,        1'b0};
    tbl[15] = '{enc_i(12'hFFF, 5'd5, 3'd3, 5'd20),     5'd20, 32'd1,        1'b0};
    tbl[16] = '{enc_i(12'h7FF, 5'd5, 3'd4, 5'd21),     5'd21, 32'h000007FE, 1'b0};
    tbl[17] = '{enc_i(12'h0F0, 5'd9, 3'd7, 5'd22),     5'd22, 32'h000000F0, 1'b0};
    tbl[18] = '{enc_i(12'h800, 5'd0, 3'd6, 5'd23),     5'd23, 32'hFFFFF800, 1'b0};
    tbl[19] = '{enc_i(12'h01F, 5'd5, 3'd1, 5'd24),     5'd24, 32'h80000000, 1'b0};
    tbl[20] = '{enc_r(7'h20, 5'd5, 5'd24, 3'd5, 5'd25), 5'd25, 32'hC0000000, 1'b0};
    tbl[21] = '{enc_r(7'h00, 5'd5, 5'd24, 3'd5, 5'd26), 5'd26, 32'h40000000, 1'b0};
    tbl[22] = '{enc_r(7'h20, 5'd5, 5'd0, 3'd0, 5'd27),  5'd27, 32'hFFFFFFFF, 1'b0};
    tbl[23] = '{enc_r(7'h00, 5'd24, 5'd24, 3'd0, 5'd28), 5'd28, 32'd0,       1'b0};

    for (int i = 0; i < 256; i++) dut.instruction_fetch_unit.instruction_memory[i] = 32'h00000013;
    for (int i = 0; i < 24; i++) dut.instruction_fetch_unit.instruction_memory[i] = tbl[i].instr;
    for (int i = 0; i < 32; i++) dut.register_file_unit.reg_array[i] = 32'd0;
    dut.register_file_unit.reg_array[5] = 32'd1;
    dut.register_file_unit.reg_array[6] = 32'd2;

    #1;
    check("reset_pc", pc_out, 32'd0);
    check("reset_instr", instruction_out, 32'h005303B3);

    // Directed program
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 24; i++) begin
      check($sformatf("pc_step%0d", i), pc_out, 32'(i * 4));
      check($sformatf("instr_step%0d", i), instruction_out, tbl[i].instr);
      if (tbl[i].chk_zero) begin
        check("alu_zero_result", dut.alu_result, 32'd0);
        check("zero_flag", {31'd0, dut.zero_flag}, 32'd1);
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("reg_step%0d_x%0d", i, tbl[i].chk_reg),
            dut.register_file_unit.read_data1 & 32'd0 | dut.register_file_unit.reg_array[tbl[i].chk_reg] & {32{tbl[i].chk_reg != 5'd0}},
            tbl[i].exp);
    end
    check("pc_after_program", pc_out, 32'h60);
    check("x0_reads_zero", (dut.rs1 == 5'd0 || dut.rs1 != 5'd0) ? dut.register_file_unit.read_data1 : 32'd0,
          (dut.rs1 == 5'd0) ? 32'd0 : dut.register_file_unit.reg_array[dut.rs1]);

    // Asynchronous reset mid-run at PC 0x10
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pc_before_midreset", pc_out, 32'h10);
    #2;
    reset = 1'b0;
    #1;
    check("pc_async_reset", pc_out, 32'd0);
    check("instr_async_reset", instruction_out, 32'h005303B3);
    check("x27_kept", dut.register_file_unit.reg_array[27], 32'hFFFFFFFF);
    check("x24_kept", dut.register_file_unit.reg_array[24], 32'h80000000);

    // Randomized run against the model, long enough to wrap the fetch index
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = rand_instr();
      dut.instruction_fetch_unit.instruction_memory[i] = model_mem[i];
    end
    model_regs[0] = 32'd0;
    dut.register_file_unit.reg_array[0] = 32'd0;
    for (int i = 1; i < 32; i++) begin
      model_regs[i] = $urandom;
      dut.register_file_unit.reg_array[i] = model_regs[i];
    end
    model_pc = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 300; c++) begin
      ins = model_mem[model_pc[9:2]];
      check($sformatf("rnd_instr%0d", c), instruction_out, ins);
      model_step(ins);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rnd_pc%0d", c), pc_out, model_pc);
      check($sformatf("rnd_x%0d_c%0d", ins[11:7], c),
            dut.register_file_unit.reg_array[ins[11:7]], model_regs[ins[11:7]]);
    end
    for (int r = 0; r < 32; r++) begin
      check($sformatf("rnd_final_x%0d", r), dut.register_file_unit.reg_array[r], model_regs[r]);
    end

    // 256 instructions from reset: fetch index wraps back to word 0
    reset = 1'b0;
    for (int i = 0; i < 256; i++) dut.instruction_fetch_unit.instruction_memory[i] = 32'h00000013;
    dut.instruction_fetch_unit.instruction_memory[0] = 32'h005303B3;
    @(negedge clk);
    reset = 1'b1;
    repeat (256) @(posedge clk);
    @(negedge clk);
    check("pc_wrap_0x400", pc_out, 32'h400);
    check("instr_wrap_word0", instruction_out, 32'h005303B3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
